// File: rtl/eco32_core_xpu_fadd_pkg.sv
// Shared constants for the eco32 XPU floating-point add/sub datapath.
// Provides width helpers for the extended (guard/round/sticky) operand,
// the alignment saturation threshold and the GRS bit positions.
package eco32_core_xpu_fadd_pkg;

    // Width of an extended operand: mantissa plus guard, round, sticky.
    function automatic int fadd_wx(input int mant_w);
        return mant_w + 3;
    endfunction

    // Width of a leading-zero count over the extended operand (0..W_X).
    function automatic int fadd_lz_w(input int mant_w);
        return $clog2(mant_w + 4);
    endfunction

    // Any alignment shift at or beyond this leaves only the sticky bit.
    function automatic int fadd_sat_shift(input int mant_w);
        return mant_w + 3;
    endfunction

    localparam int GRS_G_BIT = 2;
    localparam int GRS_R_BIT = 1;
    localparam int GRS_S_BIT = 0;

endpackage

// File: rtl/eco32_core_xpu_lzc.sv
// Combinational leading-zero counter (priority encoder).
// Ports:
//   value  in  W      vector to scan, MSB first
//   count  out CNT_W  number of leading zeros; W when value is all zero
module eco32_core_xpu_lzc #(
    parameter int W     = 27,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     value,
    output logic [CNT_W-1:0] count
);

    // Scan upward so the most significant set bit is the last to assign.
    always_comb begin
        count = CNT_W'(W);
        for (int i = 0; i < W; i++) begin
            if (value[i]) begin
                count = CNT_W'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/eco32_core_xpu_fadd_align.sv
// eco32 XPU floating-point add/sub alignment and magnitude core.
// Aligns the smaller-exponent mantissa with full guard/round/sticky
// capture, adds or subtracts, returns a magnitude with sign-flip flag,
// and counts leading zeros for the normaliser. Three-stage valid pipeline
// with flush.
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   i_stb, i_flush    input valid; kill all in-flight operations
//   i_exp_diff        exp_a - exp_b (unsigned, exp_a >= exp_b)
//   i_mant_a/b        larger / smaller exponent mantissas
//   i_sub             1 = effective subtraction
//   o_stb             result valid (3 edges after i_stb)
//   o_carry, o_mant, o_grs   result magnitude {carry, mant, g, r, s}
//   o_sign_flip       a - b was negative; magnitude returned
//   o_zero, o_lz      exact zero; leading zeros of {o_mant, o_grs}
module eco32_core_xpu_fadd_align
    import eco32_core_xpu_fadd_pkg::*;
#(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8,
    parameter int LZ_W   = fadd_lz_w(MANT_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_stb,
    input  logic              i_flush,
    input  logic [EXP_W-1:0]  i_exp_diff,
    input  logic [MANT_W-1:0] i_mant_a,
    input  logic [MANT_W-1:0] i_mant_b,
    input  logic              i_sub,
    output logic              o_stb,
    output logic              o_carry,
    output logic [MANT_W-1:0] o_mant,
    output logic [2:0]        o_grs,
    output logic              o_sign_flip,
    output logic              o_zero,
    output logic [LZ_W-1:0]   o_lz
);

    localparam int W_X       = fadd_wx(MANT_W);
    localparam int SAT_SHIFT = fadd_sat_shift(MANT_W);

    // Coarse shift of {b, 000} by a multiple of 4; returns {shifted, sticky}.
    // Shifts past the saturation point keep only |b as sticky.
    function automatic logic [W_X:0] align_coarse(input logic [MANT_W-1:0] b,
                                                  input logic [EXP_W-1:0]  amt);
        logic [2*W_X-1:0] wide;
        logic [W_X:0]     res;
        if (int'(amt) >= SAT_SHIFT) begin
            res = {{W_X{1'b0}}, |b};
        end else begin
            wide = {b, 3'b000, {W_X{1'b0}}} >> amt;
            res  = {wide[2*W_X-1:W_X], |wide[W_X-1:0]};
        end
        return res;
    endfunction

    // Fine shift by 0..3 and fold all lost bits into the sticky position.
    function automatic logic [W_X-1:0] align_fine(input logic [W_X-1:0] c,
                                                  input logic           st,
                                                  input logic [1:0]     sh);
        logic [W_X+2:0] wide;
        logic [W_X-1:0] bx;
        wide = {c, 3'b000} >> sh;
        bx   = wide[W_X+2:3];
        bx[GRS_S_BIT] = bx[GRS_S_BIT] | st | (|wide[2:0]);
        return bx;
    endfunction

    // Magnitude of a signed sum; the sum never needs more than W_X+1 bits.
    function automatic logic [W_X:0] abs_mag(input logic signed [W_X+1:0] r);
        logic signed [W_X+1:0] n;
        n = -r;
        return r[W_X+1] ? n[W_X:0] : r[W_X:0];
    endfunction

    logic [EXP_W-1:0] coarse_amt;
    logic [W_X:0]     coarse_res;

    logic              vld_p1;
    logic              sub_p1;
    logic [MANT_W-1:0] mant_a_p1;
    logic [W_X-1:0]    coarse_p1;
    logic              sticky_p1;
    logic [1:0]        fine_p1;

    logic [W_X-1:0]          bx_s2;
    logic signed [W_X+1:0]   res_s2;

    logic         vld_p2;
    logic [W_X:0] mag_p2;
    logic         flip_p2;

    logic [LZ_W-1:0] lz_s3;
    logic            zero_s3;

    assign coarse_amt = {i_exp_diff[EXP_W-1:2], 2'b00};
    assign coarse_res = align_coarse(i_mant_b, coarse_amt);

    assign bx_s2  = align_fine(coarse_p1, sticky_p1, fine_p1);
    assign res_s2 = sub_p1 ? (signed'({2'b00, mant_a_p1, 3'b000}) - signed'({2'b00, bx_s2}))
                           : (signed'({2'b00, mant_a_p1, 3'b000}) + signed'({2'b00, bx_s2}));

    eco32_core_xpu_lzc #(
        .W     (W_X),
        .CNT_W (LZ_W)
    ) u_lzc (
        .value (mag_p2[W_X-1:0]),
        .count (lz_s3)
    );

    assign zero_s3 = (mag_p2 == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            sub_p1      <= 1'b0;
            mant_a_p1   <= '0;
            coarse_p1   <= '0;
            sticky_p1   <= 1'b0;
            fine_p1     <= '0;
            vld_p2      <= 1'b0;
            mag_p2      <= '0;
            flip_p2     <= 1'b0;
            o_stb       <= 1'b0;
            o_carry     <= 1'b0;
            o_mant      <= '0;
            o_grs       <= '0;
            o_sign_flip <= 1'b0;
            o_zero      <= 1'b0;
            o_lz        <= '0;
        end else begin
            // S1: coarse alignment
            vld_p1    <= i_stb & ~i_flush;
            sub_p1    <= i_sub;
            mant_a_p1 <= i_mant_a;
            coarse_p1 <= coarse_res[W_X:1];
            sticky_p1 <= coarse_res[0];
            fine_p1   <= i_exp_diff[1:0];
            // S2: fine alignment, add/sub, magnitude
            vld_p2    <= vld_p1 & ~i_flush;
            mag_p2    <= abs_mag(res_s2);
            flip_p2   <= res_s2[W_X+1];
            // S3: leading-zero count, zero detect, outputs
            o_stb       <= vld_p2 & ~i_flush;
            o_carry     <= mag_p2[W_X];
            o_mant      <= mag_p2[W_X-1:3];
            o_grs       <= {mag_p2[GRS_G_BIT], mag_p2[GRS_R_BIT], mag_p2[GRS_S_BIT]};
            o_sign_flip <= flip_p2;
            o_zero      <= zero_s3;
            o_lz        <= (zero_s3 | mag_p2[W_X]) ? '0 : lz_s3;
        end
    end

endmodule

// File: tb/tb_eco32_core_xpu_fadd_align.sv
// Self-checking bench for eco32_core_xpu_fadd_align (MANT_W=24, EXP_W=8).
// Directed vectors with hand-computed results, pipeline flush and reset
// scenarios, then randomized traffic against an arithmetic reference model.
module tb_eco32_core_xpu_fadd_align;

    localparam int MANT_W = 24;
    localparam int EXP_W  = 8;
    localparam int LZ_W   = 5;

    typedef struct packed {
        logic        carry;
        logic [23:0] mant;
        logic [2:0]  grs;
        logic        flip;
        logic        zero;
        logic [4:0]  lz;
    } res_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_stb = 1'b0;
    logic              i_flush = 1'b0;
    logic [EXP_W-1:0]  i_exp_diff = '0;
    logic [MANT_W-1:0] i_mant_a = '0;
    logic [MANT_W-1:0] i_mant_b = '0;
    logic              i_sub = 1'b0;
    logic              o_stb;
    logic              o_carry;
    logic [MANT_W-1:0] o_mant;
    logic [2:0]        o_grs;
    logic              o_sign_flip;
    logic              o_zero;
    logic [LZ_W-1:0]   o_lz;

    int errors = 0;
    int checks = 0;
    int stb_seen = 0;

    // Expected contents after 1, 2, 3 edges of latency; slot 3 is the output.
    logic lv [1:3];
    res_t lr [1:3];

    always #5 clk = ~clk;

    eco32_core_xpu_fadd_align #(
        .MANT_W (MANT_W),
        .EXP_W  (EXP_W),
        .LZ_W   (LZ_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_stb       (i_stb),
        .i_flush     (i_flush),
        .i_exp_diff  (i_exp_diff),
        .i_mant_a    (i_mant_a),
        .i_mant_b    (i_mant_b),
        .i_sub       (i_sub),
        .o_stb       (o_stb),
        .o_carry     (o_carry),
        .o_mant      (o_mant),
        .o_grs       (o_grs),
        .o_sign_flip (o_sign_flip),
        .o_zero      (o_zero),
        .o_lz        (o_lz)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Plain integer arithmetic: b scaled by 8, shifted by d, lost bits -> sticky.
    function automatic res_t ref_model(input logic [23:0] a, input logic [23:0] b,
                                       input logic [7:0] d, input logic sub);
        longint ax, bx, full, r, mag;
        int k;
        res_t res;
        ax   = longint'(a) * 8;
        full = longint'(b) * 8;
        if (d >= 27) begin
            bx = (b != 0) ? 1 : 0;
        end else begin
            bx = full >> d;
            if ((full % (longint'(1) << d)) != 0) bx = bx | 1;
        end
        r   = sub ? ax - bx : ax + bx;
        mag = (r < 0) ? -r : r;
        res.flip  = (r < 0);
        res.carry = (mag >= (longint'(1) << 27));
        res.mant  = 24'((mag / 8) % (longint'(1) << 24));
        res.grs   = 3'(mag % 8);
        res.zero  = (mag == 0);
        k = 0;
        while ((mag >> k) > 1) k++;
        res.lz = (res.zero || res.carry) ? 5'd0 : 5'(26 - k);
        return res;
    endfunction

    task automatic check_outputs(input string tag, input res_t e);
        chk({tag, ".carry"}, 32'(o_carry), 32'(e.carry));
        chk({tag, ".mant"},  32'(o_mant),  32'(e.mant));
        chk({tag, ".grs"},   32'(o_grs),   32'(e.grs));
        chk({tag, ".flip"},  32'(o_sign_flip), 32'(e.flip));
        chk({tag, ".zero"},  32'(o_zero),  32'(e.zero));
        chk({tag, ".lz"},    32'(o_lz),    32'(e.lz));
    endtask

    // One clock: drive at negedge, advance model at the edge, check at next negedge.
    task automatic step(input logic stb, input logic flush, input logic [23:0] a,
                        input logic [23:0] b, input logic [7:0] d, input logic sub);
        i_stb = stb; i_flush = flush; i_mant_a = a; i_mant_b = b;
        i_exp_diff = d; i_sub = sub;
        @(posedge clk);
        lv[3] = lv[2]; lr[3] = lr[2];
        lv[2] = lv[1]; lr[2] = lr[1];
        lv[1] = stb;   lr[1] = ref_model(a, b, d, sub);
        if (flush) begin
            lv[1] = 1'b0; lv[2] = 1'b0; lv[3] = 1'b0;
        end
        @(negedge clk);
        chk("o_stb", 32'(o_stb), 32'(lv[3]));
        if (o_stb) stb_seen++;
        if (lv[3]) check_outputs("model", lr[3]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 24'h0, 24'h0, 8'h0, 1'b0);
    endtask

    // Single op followed by idle cycles; result compared with hand values.
    task automatic directed(input string tag, input logic [23:0] a, input logic [23:0] b,
                            input logic [7:0] d, input logic sub, input res_t e);
        step(1'b1, 1'b0, a, b, d, sub);
        idle(2);
        chk({tag, ".stb"}, 32'(o_stb), 32'd1);
        check_outputs(tag, e);
        idle(1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".stb"},   32'(o_stb),   32'd0);
        chk({tag, ".carry"}, 32'(o_carry), 32'd0);
        chk({tag, ".mant"},  32'(o_mant),  32'd0);
        chk({tag, ".grs"},   32'(o_grs),   32'd0);
        chk({tag, ".flip"},  32'(o_sign_flip), 32'd0);
        chk({tag, ".zero"},  32'(o_zero),  32'd0);
        chk({tag, ".lz"},    32'(o_lz),    32'd0);
    endtask

    initial begin
        logic [23:0] a, b;
        logic [7:0]  d;
        logic        stb, fl, sub;

        for (int i = 1; i <= 3; i++) begin lv[i] = 1'b0; lr[i] = '0; end

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Directed vectors: {carry, mant, grs, flip, zero, lz}
        directed("add_eq",   24'h800000, 24'h800000, 8'd0,   1'b0, '{1'b1, 24'h000000, 3'b000, 1'b0, 1'b0, 5'd0});
        directed("sub_flip", 24'h800000, 24'hC00000, 8'd0,   1'b1, '{1'b0, 24'h400000, 3'b000, 1'b1, 1'b0, 5'd1});
        directed("guard",    24'h800000, 24'h800001, 8'd1,   1'b0, '{1'b0, 24'hC00000, 3'b100, 1'b0, 1'b0, 5'd0});
        directed("sat_add",  24'h800000, 24'h000001, 8'd40,  1'b0, '{1'b0, 24'h800000, 3'b001, 1'b0, 1'b0, 5'd0});
        directed("sat_sub",  24'h800000, 24'h000001, 8'd40,  1'b1, '{1'b0, 24'h7FFFFF, 3'b111, 1'b0, 1'b0, 5'd1});
        directed("sat255a",  24'h800000, 24'h000001, 8'd255, 1'b0, '{1'b0, 24'h800000, 3'b001, 1'b0, 1'b0, 5'd0});
        directed("sat255s",  24'h800000, 24'h000001, 8'd255, 1'b1, '{1'b0, 24'h7FFFFF, 3'b111, 1'b0, 1'b0, 5'd1});
        directed("sat27s",   24'h800000, 24'h000001, 8'd27,  1'b1, '{1'b0, 24'h7FFFFF, 3'b111, 1'b0, 1'b0, 5'd1});
        directed("zero",     24'h9ABCDE, 24'h9ABCDE, 8'd0,   1'b1, '{1'b0, 24'h000000, 3'b000, 1'b0, 1'b1, 5'd0});

        // Flush: op3 presented with flush; ops 1-3 lost, ops 4-5 survive
        stb_seen = 0;
        step(1'b1, 1'b0, 24'h812345, 24'h400001, 8'd3, 1'b0);
        step(1'b1, 1'b0, 24'hA00000, 24'h900000, 8'd1, 1'b1);
        step(1'b1, 1'b1, 24'hF00000, 24'h0000FF, 8'd9, 1'b0);
        step(1'b1, 1'b0, 24'hC00003, 24'h123456, 8'd5, 1'b1);
        step(1'b1, 1'b0, 24'h800000, 24'hFFFFFF, 8'd0, 1'b1);
        idle(3);
        chk("flush_cnt", 32'(stb_seen), 32'd2);

        // Asynchronous reset mid-stream
        step(1'b1, 1'b0, 24'hFEDCBA, 24'h876543, 8'd2, 1'b0);
        step(1'b1, 1'b0, 24'h9ABCDE, 24'h123457, 8'd6, 1'b1);
        step(1'b1, 1'b0, 24'hABCDEF, 24'hABCDEF, 8'd0, 1'b0);
        chk("pre_rst.stb", 32'(o_stb), 32'd1);
        i_stb = 1'b0;
        #2 rst = 1'b1;
        #1 check_all_zero("mid_rst");
        for (int i = 1; i <= 3; i++) lv[i] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        stb_seen = 0;
        idle(3);
        chk("post_rst_cnt", 32'(stb_seen), 32'd0);
        directed("after_rst", 24'h800000, 24'h800001, 8'd1, 1'b0, '{1'b0, 24'hC00000, 3'b100, 1'b0, 1'b0, 5'd0});

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            stb = ($urandom_range(0, 9) < 8);
            fl  = ($urandom_range(0, 19) == 0);
            sub = 1'($urandom_range(0, 1));
            a   = 24'h800000 | 24'($urandom);
            case ($urandom_range(0, 3))
                0:       d = 8'($urandom_range(0, 3));
                1:       d = 8'($urandom_range(0, 31));
                2:       d = 8'($urandom);
                default: d = 8'd0;
            endcase
            b = 24'($urandom);
            if ($urandom_range(0, 1) == 1) b = b | 24'h800000;
            if (d == 0 && $urandom_range(0, 3) == 0) b = a;
            step(stb, fl, a, b, d, sub);
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
